// File: rtl/apb_arbiter_master.sv
// Two-requester round-robin APB master: arbitrates local requests, sequences
// IDLE/SETUP/ACCESS, handles wait states, slave errors and a stuck-slave timeout.
module apb_arbiter_master #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                PCLK,
  input  logic                PRESETn,
  input  logic [1:0]          REQ,
  input  logic [1:0]          REQ_WRITE,
  input  logic [2*ADDR_W-1:0] REQ_ADDR,
  input  logic [2*DATA_W-1:0] REQ_WDATA,
  output logic [1:0]          DONE,
  output logic [DATA_W-1:0]   RDATA,
  output logic                ERR,
  output logic                PSEL,
  output logic                PENABLE,
  output logic                PWRITE,
  output logic [ADDR_W-1:0]   PADDR,
  output logic [DATA_W-1:0]   PWDATA,
  input  logic [DATA_W-1:0]   PRDATA,
  input  logic                PREADY,
  input  logic                PSLVERR
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;

  localparam int TO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam int CNT_W   = (TO_LAST > 0) ? $clog2(TO_LAST + 1) : 1;
  localparam logic [CNT_W-1:0] TO_LAST_C = CNT_W'(TO_LAST);

  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  req_t [1:0] req_pl;

  for (genvar gi = 0; gi < 2; gi++) begin : g_req
    assign req_pl[gi] = {REQ_WRITE[gi], REQ_ADDR[gi*ADDR_W +: ADDR_W],
                         REQ_WDATA[gi*DATA_W +: DATA_W]};
  end

  logic [1:0]        state_q,   state_d;
  logic              last_q,    last_d;
  logic              gnt_q,     gnt_d;
  logic [CNT_W-1:0]  cnt_q,     cnt_d;
  logic [1:0]        done_q,    done_d;
  logic [DATA_W-1:0] rdata_q,   rdata_d;
  logic              err_q,     err_d;
  logic              psel_q,    psel_d;
  logic              penable_q, penable_d;
  logic              pwrite_q,  pwrite_d;
  logic [ADDR_W-1:0] paddr_q,   paddr_d;
  logic [DATA_W-1:0] pwdata_q,  pwdata_d;

  logic [1:0] gnt_mask;
  logic       completing;
  logic [1:0] elig;
  logic       any_elig;
  logic       pick;
  req_t       sel;

  // A requester is masked while its DONE is visible and in the cycle it completes,
  // so a held REQ is not mistaken for a fresh request.
  always_comb begin
    gnt_mask   = gnt_q ? 2'b10 : 2'b01;
    completing = (state_q == ST_ACCESS) && PREADY;
    elig       = REQ & ~done_q & ~(completing ? gnt_mask : 2'b00);
    any_elig   = |elig;
    case (elig)
      2'b01:   pick = 1'b0;
      2'b10:   pick = 1'b1;
      default: pick = ~last_q;
    endcase
    sel = req_pl[pick];
  end

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    gnt_d     = gnt_q;
    cnt_d     = cnt_q;
    done_d    = 2'b00;
    rdata_d   = rdata_q;
    err_d     = err_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    pwrite_d  = pwrite_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;

    case (state_q)
      ST_IDLE: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
        if (any_elig) begin
          gnt_d    = pick;
          last_d   = pick;
          pwrite_d = sel.wr;
          paddr_d  = sel.addr;
          pwdata_d = sel.wdata;
          psel_d   = 1'b1;
          state_d  = ST_SETUP;
        end
      end
      ST_SETUP: begin
        penable_d = 1'b1;
        cnt_d     = '0;
        state_d   = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (PREADY) begin
          done_d    = gnt_mask;
          err_d     = PSLVERR;
          if (!pwrite_q) rdata_d = PRDATA;
          penable_d = 1'b0;
          if (any_elig) begin
            // back-to-back: PSEL stays high, straight into SETUP for the other side
            gnt_d    = pick;
            last_d   = pick;
            pwrite_d = sel.wr;
            paddr_d  = sel.addr;
            pwdata_d = sel.wdata;
            state_d  = ST_SETUP;
          end else begin
            psel_d  = 1'b0;
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
          if ((TIMEOUT != 0) && (cnt_q == TO_LAST_C)) begin
            done_d    = gnt_mask;
            err_d     = 1'b1;
            psel_d    = 1'b0;
            penable_d = 1'b0;
            state_d   = ST_IDLE;
          end
        end
      end
      default: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
        state_d   = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q   <= ST_IDLE;
      last_q    <= 1'b1;
      gnt_q     <= 1'b0;
      cnt_q     <= '0;
      done_q    <= 2'b00;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      gnt_q     <= gnt_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
    end
  end

  assign DONE    = done_q;
  assign RDATA   = rdata_q;
  assign ERR     = err_q;
  assign PSEL    = psel_q;
  assign PENABLE = penable_q;
  assign PWRITE  = pwrite_q;
  assign PADDR   = paddr_q;
  assign PWDATA  = pwdata_q;

endmodule

// File: tb/tb_apb_arbiter_master.sv
// Bench for apb_arbiter_master: table of single transfers, then contention,
// timeout and reset-mid-access sequences, all scored against an expected queue.
module tb_apb_arbiter_master;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;

  logic          PCLK = 1'b0;
  logic          PRESETn = 1'b0;
  logic [1:0]    REQ = 2'b00;
  logic [1:0]    REQ_WRITE = 2'b00;
  logic [2*AW-1:0] REQ_ADDR = '0;
  logic [2*DW-1:0] REQ_WDATA = '0;
  logic [1:0]    DONE;
  logic [DW-1:0] RDATA;
  logic          ERR, PSEL, PENABLE, PWRITE;
  logic [AW-1:0] PADDR;
  logic [DW-1:0] PWDATA, PRDATA;
  logic          PREADY, PSLVERR;

  apb_arbiter_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .REQ(REQ), .REQ_WRITE(REQ_WRITE),
    .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA), .DONE(DONE), .RDATA(RDATA),
    .ERR(ERR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  // slave: PREADY rises after slv_waits ACCESS cycles
  int          slv_waits = 0;
  logic [31:0] slv_rdata = '0;
  logic        slv_err = 1'b0;
  int          acc_cnt = 0;
  always @(posedge PCLK) acc_cnt <= (PSEL && PENABLE && !PREADY) ? acc_cnt + 1 : 0;
  assign PREADY  = PSEL && PENABLE && (acc_cnt >= slv_waits);
  assign PRDATA  = slv_rdata;
  assign PSLVERR = slv_err && PREADY;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  typedef struct {
    logic [1:0]  id_mask;
    logic        wr;
    logic [31:0] addr, wdata, rdata;
    logic        err;
    logic        to;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] mdl_rdata = '0;
  logic [1:0]  prev_done = 2'b00;

  always @(negedge PCLK) begin
    exp_t e;
    if (!PRESETn) mdl_rdata = '0;
    if (PSEL && PENABLE && PREADY) begin
      if (sbq.size() == 0) chk("bus_unexpected", 32'd1, 32'd0);
      else begin
        chk("paddr", PADDR, sbq[0].addr);
        chk("pwrite", 32'(PWRITE), 32'(sbq[0].wr));
        if (sbq[0].wr) chk("pwdata", PWDATA, sbq[0].wdata);
      end
    end
    if (DONE != 2'b00) begin
      chk("done_pulse_width", 32'(DONE & prev_done), 32'd0);
      if (sbq.size() == 0) chk("done_unexpected", 32'(DONE), 32'd0);
      else begin
        e = sbq.pop_front();
        chk("done_id", 32'(DONE), 32'(e.id_mask));
        chk("err", 32'(ERR), 32'(e.err | e.to));
        if (!e.wr && !e.to) mdl_rdata = e.rdata;
        chk("rdata", RDATA, mdl_rdata);
      end
    end
    prev_done = DONE;
  end

  typedef struct {
    int          id;
    logic        wr;
    logic [31:0] addr, wdata, rdata;
    int          waits;
    logic        slverr;
    logic        exp_err;
    logic        exp_to;
    int          exp_pen;
    int          exp_psel;
  } vec_t;

  function automatic exp_t mk_exp(input int id, input logic wr, input logic [31:0] addr,
                                  input logic [31:0] wdata, input logic [31:0] rdata,
                                  input logic err, input logic to);
    exp_t e;
    e.id_mask = (id == 0) ? 2'b01 : 2'b10;
    e.wr = wr; e.addr = addr; e.wdata = wdata; e.rdata = rdata; e.err = err; e.to = to;
    return e;
  endfunction

  task automatic run_vec(input vec_t v);
    int pen, ps;
    bit got;
    slv_waits = v.waits; slv_rdata = v.rdata; slv_err = v.slverr;
    REQ_WRITE[v.id] = v.wr;
    REQ_ADDR[v.id*AW +: AW] = v.addr;
    REQ_WDATA[v.id*DW +: DW] = v.wdata;
    REQ[v.id] = 1'b1;
    sbq.push_back(mk_exp(v.id, v.wr, v.addr, v.wdata, v.rdata, v.exp_err, v.exp_to));
    pen = 0; ps = 0; got = 0;
    for (int c = 0; c < 40 && !got; c++) begin
      @(posedge PCLK); #1;
      if (DONE[v.id]) begin
        got = 1;
        chk("psel_after_done", 32'(PSEL), 32'd0);
      end else begin
        ps += int'(PSEL);
        pen += int'(PENABLE);
      end
    end
    if (!got) chk("wait_done_expired", 32'd0, 32'd1);
    chk("penable_cycles", 32'(pen), 32'(v.exp_pen));
    chk("psel_cycles", 32'(ps), 32'(v.exp_psel));
    REQ[v.id] = 1'b0;
    @(posedge PCLK); #1;
  endtask

  vec_t vt[7];

  initial begin
    int pen, ps, ndone;
    int cnt[2];
    bit rearm[2];
    bit got;
    logic [31:0] addr_n[2];

    //              id wr    addr      wdata         rdata         w se  err to pen psel
    vt[0] = '{0, 1'b1, 32'h10, 32'hDEADBEEF, 32'h0,        0, 1'b0, 1'b0, 1'b0, 1, 2};
    vt[1] = '{1, 1'b0, 32'h20, 32'h0,        32'h12345678, 2, 1'b0, 1'b0, 1'b0, 3, 4};
    vt[2] = '{0, 1'b1, 32'h30, 32'h0A0B0C0D, 32'h0,        0, 1'b1, 1'b1, 1'b0, 1, 2};
    vt[3] = '{1, 1'b0, 32'h40, 32'h0,        32'hCAFEF00D, 0, 1'b0, 1'b0, 1'b0, 1, 2};
    vt[4] = '{0, 1'b0, 32'h50, 32'h0,        32'hBAD0BAD0, 6, 1'b0, 1'b0, 1'b1, 4, 5};
    vt[5] = '{1, 1'b1, 32'h60, 32'h11223344, 32'h0,        1, 1'b0, 1'b0, 1'b0, 2, 3};
    vt[6] = '{0, 1'b0, 32'h70, 32'h0,        32'h55667788, 3, 1'b0, 1'b0, 1'b0, 4, 5};

    // reset state
    #3;
    chk("rst_psel", 32'(PSEL), 32'd0);
    chk("rst_penable", 32'(PENABLE), 32'd0);
    chk("rst_done", 32'(DONE), 32'd0);
    chk("rst_err", 32'(ERR), 32'd0);
    chk("rst_rdata", RDATA, 32'd0);
    chk("rst_paddr", PADDR, 32'd0);
    repeat (2) @(posedge PCLK);
    #1 PRESETn = 1'b1;
    @(posedge PCLK); #1;

    for (int i = 0; i < 7; i++) run_vec(vt[i]);

    // contention from reset: grants 0,1,0,1 with PSEL held across hand-overs
    PRESETn = 1'b0;
    repeat (2) @(posedge PCLK);
    #1 PRESETn = 1'b1;
    slv_waits = 0; slv_err = 1'b0; slv_rdata = 32'h0BADF00D;
    addr_n[0] = 32'h100; addr_n[1] = 32'h200;
    REQ_WRITE = 2'b10;
    REQ_ADDR  = {addr_n[1], addr_n[0]};
    REQ_WDATA = {32'h000200AA, 32'h0};
    sbq.push_back(mk_exp(0, 1'b0, 32'h100, 32'h0, 32'h0BADF00D, 1'b0, 1'b0));
    sbq.push_back(mk_exp(1, 1'b1, 32'h200, 32'h000200AA, 32'h0, 1'b0, 1'b0));
    sbq.push_back(mk_exp(0, 1'b0, 32'h104, 32'h0, 32'h0BADF00D, 1'b0, 1'b0));
    sbq.push_back(mk_exp(1, 1'b1, 32'h204, 32'h000200AA, 32'h0, 1'b0, 1'b0));
    REQ = 2'b11;
    pen = 0; ps = 0; ndone = 0;
    cnt[0] = 0; cnt[1] = 0; rearm[0] = 0; rearm[1] = 0;
    for (int c = 0; c < 60 && ndone < 4; c++) begin
      @(posedge PCLK); #1;
      for (int i = 0; i < 2; i++) if (rearm[i]) begin
        addr_n[i] = addr_n[i] + 32'd4;
        REQ_ADDR[i*AW +: AW] = addr_n[i];
        REQ[i] = 1'b1;
        rearm[i] = 0;
      end
      for (int i = 0; i < 2; i++) if (DONE[i]) begin
        REQ[i] = 1'b0;
        cnt[i]++;
        ndone++;
        rearm[i] = (cnt[i] < 2);
      end
      if (ndone < 4) begin
        ps += int'(PSEL);
        pen += int'(PENABLE);
      end
    end
    chk("contention_done_count", 32'(ndone), 32'd4);
    chk("contention_psel_cycles", 32'(ps), 32'd8);
    chk("contention_penable_cycles", 32'(pen), 32'd4);
    REQ = 2'b00;
    @(posedge PCLK); #1;

    // reset during ACCESS drops the bus asynchronously; request re-served afterwards
    slv_waits = 100;
    REQ_WRITE[0] = 1'b0;
    REQ_ADDR[0 +: AW] = 32'h300;
    REQ[0] = 1'b1;
    got = 0;
    for (int c = 0; c < 10 && !got; c++) begin
      @(posedge PCLK); #1;
      got = PENABLE;
    end
    if (!got) chk("wait_access_expired", 32'd0, 32'd1);
    #2 PRESETn = 1'b0;
    #1;
    chk("async_rst_psel", 32'(PSEL), 32'd0);
    chk("async_rst_penable", 32'(PENABLE), 32'd0);
    chk("async_rst_done", 32'(DONE), 32'd0);
    slv_waits = 0; slv_rdata = 32'h77778888;
    sbq.push_back(mk_exp(0, 1'b0, 32'h300, 32'h0, 32'h77778888, 1'b0, 1'b0));
    @(posedge PCLK); #1;
    PRESETn = 1'b1;
    @(posedge PCLK); #1;
    chk("post_rst_setup_psel", 32'(PSEL), 32'd1);
    chk("post_rst_setup_penable", 32'(PENABLE), 32'd0);
    got = 0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(posedge PCLK); #1;
      got = DONE[0];
    end
    if (!got) chk("post_rst_done_expired", 32'd0, 32'd1);
    REQ = 2'b00;
    repeat (3) @(posedge PCLK);
    #1;
    chk("scoreboard_empty", 32'(sbq.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
